// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-triggered, masked, fixed-priority interrupt controller with RETI sequencing
module int_ctrl #(
    parameter int                 N_IRQ    = 4,
    parameter int                 ID_W     = 2,
    parameter int                 ADDR_W   = 16,
    parameter int                 OP_W     = 6,
    parameter logic [ADDR_W-1:0]  VEC_BASE = 16'hF000,
    parameter int                 VEC_SH   = 2,
    parameter logic [OP_W-1:0]    OP_EI    = 6'h1C,
    parameter logic [OP_W-1:0]    OP_DI    = 6'h1D,
    parameter logic [OP_W-1:0]    OP_RETI  = 6'h1F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_wd,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] current_address,
    output logic              interrupt,
    output logic [ADDR_W-1:0] int_vector,
    output logic [ID_W-1:0]   int_id,
    output logic              in_service,
    output logic              reti_jump,
    output logic [ADDR_W-1:0] ret_address
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE,
        S_RET
    } state_e;

    state_e              state_q, state_d;
    logic [N_IRQ-1:0]    irq_q;
    logic [N_IRQ-1:0]    pend_q, pend_d;
    logic [N_IRQ-1:0]    mask_q, mask_d;
    logic                ge_q, ge_d;
    logic                interrupt_q, interrupt_d;
    logic                in_service_q, in_service_d;
    logic                reti_jump_q, reti_jump_d;
    logic [ADDR_W-1:0]   int_vector_q, int_vector_d;
    logic [ID_W-1:0]     int_id_q, int_id_d;
    logic [ADDR_W-1:0]   ret_address_q, ret_address_d;

    logic [N_IRQ-1:0]    req;
    logic [N_IRQ-1:0]    pend_clr;
    logic [ID_W-1:0]     sel;
    logic                any_req;
    logic [ADDR_W-1:0]   sel_vector;

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        req     = pend_q & mask_q;
        sel     = '0;
        any_req = |req;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = ID_W'(i);
            end
        end
        sel_vector = VEC_BASE + (ADDR_W'(sel) << VEC_SH);
    end

    always_comb begin
        state_d       = state_q;
        interrupt_d   = 1'b0;
        in_service_d  = in_service_q;
        reti_jump_d   = 1'b0;
        int_vector_d  = int_vector_q;
        int_id_d      = int_id_q;
        ret_address_d = ret_address_q;
        pend_clr      = '0;
        case (state_q)
            S_IDLE: begin
                in_service_d = 1'b0;
                if (ge_q && any_req) begin
                    state_d       = S_REQ;
                    interrupt_d   = 1'b1;
                    in_service_d  = 1'b1;
                    int_id_d      = sel;
                    int_vector_d  = sel_vector;
                    ret_address_d = current_address;
                    pend_clr[sel] = 1'b1;
                end
            end
            S_REQ: begin
                in_service_d = 1'b1;
                state_d      = S_SERVICE;
            end
            S_SERVICE: begin
                in_service_d = 1'b1;
                if (op == OP_RETI) begin
                    reti_jump_d = 1'b1;
                    state_d     = S_RET;
                end
            end
            S_RET: begin
                // Extra cycle keeps the next REQ at least two cycles after RETI.
                in_service_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                in_service_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // A new edge outranks the clear from a selection on the same cycle.
    always_comb begin
        pend_d = (pend_q & ~pend_clr) | (irq & ~irq_q);
        mask_d = mask_we ? mask_wd : mask_q;
        ge_d   = ge_q;
        if (op == OP_EI) begin
            ge_d = 1'b1;
        end else if (op == OP_DI) begin
            ge_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            irq_q         <= '0;
            pend_q        <= '0;
            mask_q        <= '1;
            ge_q          <= 1'b0;
            interrupt_q   <= 1'b0;
            in_service_q  <= 1'b0;
            reti_jump_q   <= 1'b0;
            int_vector_q  <= '0;
            int_id_q      <= '0;
            ret_address_q <= '0;
        end else begin
            state_q       <= state_d;
            irq_q         <= irq;
            pend_q        <= pend_d;
            mask_q        <= mask_d;
            ge_q          <= ge_d;
            interrupt_q   <= interrupt_d;
            in_service_q  <= in_service_d;
            reti_jump_q   <= reti_jump_d;
            int_vector_q  <= int_vector_d;
            int_id_q      <= int_id_d;
            ret_address_q <= ret_address_d;
        end
    end

    assign interrupt   = interrupt_q;
    assign int_vector  = int_vector_q;
    assign int_id      = int_id_q;
    assign in_service  = in_service_q;
    assign reti_jump   = reti_jump_q;
    assign ret_address = ret_address_q;

endmodule
